// File: rtl/order_book_pkg.sv
// order_book_pkg: shared order-book widths, request codes and payload types.
// Holds the book_entry payload, the packed FIFO word used by the request
// issuer, the issuer FSM state type and the stock range helper.
package order_book_pkg;

   localparam int unsigned STOCK_INDEX     = 2;   // stock field is 3 bits so out-of-range ids are representable
   localparam int unsigned STOCK_W         = STOCK_INDEX + 1;
   localparam int unsigned NUM_STOCKS      = 4;
   localparam int unsigned NUM_STOCK_INDEX = 1;   // msb index of an in-range stock id
   localparam int unsigned PRICE_INDEX     = 15;
   localparam int unsigned QUANTITY_INDEX  = 15;
   localparam int unsigned ORDER_INDEX     = 7;

   localparam logic [2:0] REQ_ADD    = 3'd0;
   localparam logic [2:0] REQ_CANCEL = 3'd1;
   localparam logic [2:0] REQ_TRADE  = 3'd2;

   typedef struct packed {
      logic                    is_buy;
      logic [PRICE_INDEX:0]    price;
      logic [QUANTITY_INDEX:0] quantity;
      logic [ORDER_INDEX:0]    order_id;
   } book_entry;

   // One buffered upstream message
   typedef struct packed {
      logic [STOCK_INDEX:0]    stock;
      book_entry               entry;
      logic [2:0]              request;
      logic [ORDER_INDEX:0]    order_id;
      logic                    del;
      logic [QUANTITY_INDEX:0] quantity;
   } req_word_t;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_ACK  = 2'd2,
      ST_WAIT_DONE = 2'd3
   } issuer_state_t;

   function automatic logic stock_in_range(input logic [STOCK_INDEX:0] stock);
      return stock < STOCK_W'(NUM_STOCKS);
   endfunction

endpackage

// File: rtl/order_req_fifo.sv
// order_req_fifo: synchronous FIFO of req_word_t messages.
// Ports: i_clk, i_rst (sync, active-high), i_push/i_data write side,
// i_pop read side, o_head_c (combinational head word), o_count (registered
// occupancy), o_full_c / o_empty_c (decoded from o_count).
module order_req_fifo
   import order_book_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_push,
   input  req_word_t              i_data,
   input  logic                   i_pop,
   output req_word_t              o_head_c,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_full_c,
   output logic                   o_empty_c
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   req_word_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full_c  = (r_count == CNT_W'(DEPTH));
   assign o_empty_c = (r_count == '0);
   assign o_count   = r_count;
   assign o_head_c  = r_mem[r_rd_ptr];

   assign w_push = i_push && !o_full_c;
   assign w_pop  = i_pop && !o_empty_c;

   // Storage carries no reset; validity is tracked by the pointers/count
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/order_request_issuer.sv
// order_request_issuer: buffers parsed order messages and issues them one at
// a time to the order-book wrapper over a start/is_busy handshake.
// Ports: clk_in, rst_in (sync, active-high); msg_* valid/ready upstream;
// start + stock_to_add/order_to_add/request/order_id/delete/quantity request
// fields held stable while in flight; book_is_busy from the wrapper;
// in_flight, issued_count, dropped_count, ack_timeout_err status.
module order_request_issuer
   import order_book_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned ACK_TIMEOUT = 4
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    msg_valid,
   output logic                    msg_ready,
   input  logic [STOCK_INDEX:0]    msg_stock,
   input  book_entry               msg_entry,
   input  logic [2:0]              msg_request,
   input  logic [ORDER_INDEX:0]    msg_order_id,
   input  logic                    msg_delete,
   input  logic [QUANTITY_INDEX:0] msg_quantity,
   output logic                    start,
   output logic [STOCK_INDEX:0]    stock_to_add,
   output book_entry               order_to_add,
   output logic [2:0]              request,
   output logic [ORDER_INDEX:0]    order_id,
   output logic                    delete,
   output logic [QUANTITY_INDEX:0] quantity,
   input  logic                    book_is_busy,
   output logic                    in_flight,
   output logic [31:0]             issued_count,
   output logic [15:0]             dropped_count,
   output logic                    ack_timeout_err
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned ACK_W = $clog2(ACK_TIMEOUT + 1);

   issuer_state_t           r_state;
   issuer_state_t           w_state_next;
   logic [ACK_W-1:0]        r_ack_cnt;
   logic [ACK_W-1:0]        w_ack_cnt_next;
   logic                    r_start;
   logic                    r_in_flight;
   logic [STOCK_INDEX:0]    r_stock;
   book_entry               r_entry;
   logic [2:0]              r_request;
   logic [ORDER_INDEX:0]    r_order_id;
   logic                    r_delete;
   logic [QUANTITY_INDEX:0] r_quantity;
   logic [31:0]             r_issued;
   logic [15:0]             r_dropped;
   logic                    r_timeout_err;

   req_word_t               w_msg;
   req_word_t               w_head;
   logic [CNT_W-1:0]        w_fifo_count;
   logic                    w_fifo_full;
   logic                    w_fifo_empty;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_load;
   logic                    w_drop;
   logic                    w_ack;
   logic                    w_timeout;

   // Ready looks only at the registered count, so a full FIFO refuses a push
   // even in the cycle it pops
   assign msg_ready = !rst_in && (w_fifo_count < CNT_W'(FIFO_DEPTH));
   assign w_push    = msg_valid && !rst_in && !w_fifo_full;

   assign w_msg = '{stock:    msg_stock,
                    entry:    msg_entry,
                    request:  msg_request,
                    order_id: msg_order_id,
                    del:      msg_delete,
                    quantity: msg_quantity};

   order_req_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk     (clk_in),
      .i_rst     (rst_in),
      .i_push    (w_push),
      .i_data    (w_msg),
      .i_pop     (w_pop),
      .o_head_c  (w_head),
      .o_count   (w_fifo_count),
      .o_full_c  (w_fifo_full),
      .o_empty_c (w_fifo_empty)
   );

   // Next-state and handshake decode
   always_comb begin
      w_state_next   = r_state;
      w_ack_cnt_next = r_ack_cnt;
      w_pop          = 1'b0;
      w_load         = 1'b0;
      w_drop         = 1'b0;
      w_ack          = 1'b0;
      w_timeout      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // A busy wrapper here belongs to someone else; never issue over it
            if (!w_fifo_empty && !book_is_busy) begin
               w_pop = 1'b1;
               if (stock_in_range(w_head.stock)) begin
                  w_load       = 1'b1;
                  w_state_next = ST_ISSUE;
               end else begin
                  w_drop = 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            w_ack_cnt_next = '0;
            w_state_next   = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (book_is_busy) begin
               w_ack        = 1'b1;
               w_state_next = ST_WAIT_DONE;
            end else if (r_ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
               w_timeout    = 1'b1;
               w_state_next = ST_IDLE;
            end else begin
               w_ack_cnt_next = r_ack_cnt + ACK_W'(1);
            end
         end
         ST_WAIT_DONE: begin
            if (!book_is_busy) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // State, request fields and counters
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state       <= ST_IDLE;
         r_ack_cnt     <= '0;
         r_start       <= 1'b0;
         r_in_flight   <= 1'b0;
         r_stock       <= '0;
         r_entry       <= '0;
         r_request     <= '0;
         r_order_id    <= '0;
         r_delete      <= 1'b0;
         r_quantity    <= '0;
         r_issued      <= '0;
         r_dropped     <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_ack_cnt   <= w_ack_cnt_next;
         r_start     <= w_load;
         r_in_flight <= (w_state_next != ST_IDLE);
         // Fields change only on a new load, so they stay put while in flight
         if (w_load) begin
            r_stock    <= w_head.stock;
            r_entry    <= w_head.entry;
            r_request  <= w_head.request;
            r_order_id <= w_head.order_id;
            r_delete   <= w_head.del;
            r_quantity <= w_head.quantity;
         end
         if (w_ack) begin
            r_issued <= r_issued + 32'd1;
         end
         if (w_drop && (r_dropped != 16'hFFFF)) begin
            r_dropped <= r_dropped + 16'd1;
         end
         if (w_timeout) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

   assign start           = r_start;
   assign in_flight       = r_in_flight;
   assign stock_to_add    = r_stock;
   assign order_to_add    = r_entry;
   assign request         = r_request;
   assign order_id        = r_order_id;
   assign delete          = r_delete;
   assign quantity        = r_quantity;
   assign issued_count    = r_issued;
   assign dropped_count   = r_dropped;
   assign ack_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_order_request_issuer.sv
// tb_order_request_issuer: scoreboard bench for order_request_issuer.
// Pushed in-range messages are queued as expected requests; a monitor pops
// one per start and checks the request fields, their stability while in
// flight, and start latency. A wrapper model answers starts with busy.
module tb_order_request_issuer;
   import order_book_pkg::*;

   logic                    clk_in = 1'b0;
   logic                    rst_in;
   logic                    msg_valid;
   logic                    msg_ready;
   logic [STOCK_INDEX:0]    msg_stock;
   book_entry               msg_entry;
   logic [2:0]              msg_request;
   logic [ORDER_INDEX:0]    msg_order_id;
   logic                    msg_delete;
   logic [QUANTITY_INDEX:0] msg_quantity;
   logic                    start;
   logic [STOCK_INDEX:0]    stock_to_add;
   book_entry               order_to_add;
   logic [2:0]              request;
   logic [ORDER_INDEX:0]    order_id;
   logic                    req_delete;
   logic [QUANTITY_INDEX:0] quantity;
   logic                    book_is_busy;
   logic                    in_flight;
   logic [31:0]             issued_count;
   logic [15:0]             dropped_count;
   logic                    ack_timeout_err;

   logic ext_busy = 1'b0;
   logic wr_busy  = 1'b0;
   assign book_is_busy = wr_busy | ext_busy;

   always #5 clk_in = ~clk_in;

   order_request_issuer #(.FIFO_DEPTH(8), .ACK_TIMEOUT(4)) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .msg_valid       (msg_valid),
      .msg_ready       (msg_ready),
      .msg_stock       (msg_stock),
      .msg_entry       (msg_entry),
      .msg_request     (msg_request),
      .msg_order_id    (msg_order_id),
      .msg_delete      (msg_delete),
      .msg_quantity    (msg_quantity),
      .start           (start),
      .stock_to_add    (stock_to_add),
      .order_to_add    (order_to_add),
      .request         (request),
      .order_id        (order_id),
      .delete          (req_delete),
      .quantity        (quantity),
      .book_is_busy    (book_is_busy),
      .in_flight       (in_flight),
      .issued_count    (issued_count),
      .dropped_count   (dropped_count),
      .ack_timeout_err (ack_timeout_err)
   );

   int        total = 0;
   int        bad   = 0;
   int        cyc   = 0;
   req_word_t exp_q[$];
   int        exp_issued = 0;
   int        exp_drop   = 0;
   bit        exp_err    = 1'b0;
   int        hold       = 3;
   bit        rand_mode  = 1'b0;
   int        nack_left  = 0;
   int        busy_left  = 0;
   int        start_cyc[$];
   int        n_starts   = 0;
   bit        lat_req    = 1'b0;
   bit        lat_arm    = 1'b0;
   int        lat_exp    = 0;
   req_word_t snap;
   bit        snap_valid = 1'b0;
   req_word_t mon_cur;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk_in) cyc++;

   // Wrapper model: busy rises the cycle after start and holds for 'hold' cycles
   always begin
      @(negedge clk_in);
      if (start === 1'b1) begin
         if (rand_mode) hold = $urandom_range(1, 4);
         if (nack_left > 0 || (rand_mode && $urandom_range(0, 7) == 0)) begin
            if (nack_left > 0) nack_left--;
            exp_err = 1'b1;
         end else begin
            busy_left = hold;
            exp_issued++;
         end
      end
      @(posedge clk_in);
      #1;
      if (busy_left > 0) begin
         wr_busy = 1'b1;
         busy_left--;
      end else begin
         wr_busy = 1'b0;
      end
   end

   // Monitor: each start consumes one expected request
   always @(negedge clk_in) begin
      mon_cur = {stock_to_add, order_to_add, request, order_id, req_delete, quantity};
      if (start === 1'b1) begin
         n_starts++;
         start_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_start: got fields %0h want no start (cycle %0d)", mon_cur, cyc);
         end else begin
            chk("issue_fields", mon_cur, exp_q.pop_front());
         end
         if (lat_arm) begin
            chk("start_latency", cyc, lat_exp);
            lat_arm = 1'b0;
         end
         snap       = mon_cur;
         snap_valid = 1'b1;
      end else if (in_flight === 1'b1 && snap_valid) begin
         chk("fields_stable", mon_cur, snap);
      end
      if (in_flight !== 1'b1) snap_valid = 1'b0;
   end

   function automatic req_word_t mk(input logic [2:0] stock);
      req_word_t m;
      m.stock          = stock;
      m.entry.is_buy   = 1'($urandom_range(0, 1));
      m.entry.price    = 16'($urandom);
      m.entry.quantity = 16'($urandom);
      m.entry.order_id = 8'($urandom);
      m.request        = 3'($urandom_range(0, 2));
      m.order_id       = 8'($urandom);
      m.del            = 1'($urandom_range(0, 1));
      m.quantity       = 16'($urandom);
      return m;
   endfunction

   // Drive one message until accepted; starts and ends just after a posedge
   task automatic push(input req_word_t m, output int waited);
      bit got = 1'b0;
      waited       = 0;
      msg_valid    = 1'b1;
      msg_stock    = m.stock;
      msg_entry    = m.entry;
      msg_request  = m.request;
      msg_order_id = m.order_id;
      msg_delete   = m.del;
      msg_quantity = m.quantity;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk_in);
         if (msg_ready === 1'b1) begin
            got = 1'b1;
            break;
         end
         waited++;
         @(posedge clk_in);
         #1;
      end
      if (got) begin
         if (stock_in_range(m.stock)) exp_q.push_back(m);
         else exp_drop++;
         if (lat_req) begin
            lat_exp = cyc + 2;
            lat_arm = 1'b1;
            lat_req = 1'b0;
         end
         @(posedge clk_in);
         #1;
      end else begin
         total++;
         bad++;
         $display("FAIL push_accept: got no ready in 500 cycles want ready (cycle %0d)", cyc);
      end
      msg_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || in_flight !== 1'b0) && n < 3000) begin
         @(posedge clk_in);
         #1;
         n++;
      end
      if (n >= 3000) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending want 0 (cycle %0d)", exp_q.size(), cyc);
      end
      repeat (12) @(posedge clk_in);
      #1;
   endtask

   initial begin
      int w;
      int wsum;
      int n0;
      int sz;
      rst_in       = 1'b1;
      msg_valid    = 1'b0;
      msg_stock    = '0;
      msg_entry    = '0;
      msg_request  = '0;
      msg_order_id = '0;
      msg_delete   = 1'b0;
      msg_quantity = '0;

      // Reset state
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      chk("ready_in_reset", msg_ready, 1'b0);
      chk("start_in_reset", start, 1'b0);
      @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      @(negedge clk_in);
      chk("reset_status", {start, in_flight, issued_count, dropped_count, ack_timeout_err}, '0);
      chk("reset_fields", {stock_to_add, order_to_add, request, order_id, req_delete, quantity}, '0);
      chk("ready_after_reset", msg_ready, 1'b1);
      @(posedge clk_in);
      #1;

      // Single REQ_ADD to stock 2 with start latency
      hold    = 3;
      lat_req = 1'b1;
      begin
         req_word_t m = mk(3'd2);
         m.request = REQ_ADD;
         push(m, w);
      end
      drain();
      chk("t1_issued", issued_count, 32'd1);

      // Burst of 8 while the wrapper is held busy: FIFO fills
      hold     = 5;
      ext_busy = 1'b1;
      wsum     = 0;
      for (int i = 0; i < 8; i++) begin
         push(mk(3'($urandom_range(0, 3))), w);
         wsum += w;
      end
      chk("burst_no_stall", wsum, 0);
      @(negedge clk_in);
      chk("full_after_8", msg_ready, 1'b0);
      @(posedge clk_in);
      #1;
      // Pop at count 8: the same-cycle push must wait one cycle
      ext_busy = 1'b0;
      push(mk(3'd1), w);
      chk("full_pop_no_push", w, 1);
      drain();
      chk("burst_issued", issued_count, 32'd10);

      // Count 7 with simultaneous push and pop keeps count at 7
      ext_busy = 1'b1;
      for (int i = 0; i < 7; i++) push(mk(3'($urandom_range(0, 3))), w);
      ext_busy = 1'b0;
      push(mk(3'd0), w);
      chk("push_pop_at7_accept", w, 0);
      push(mk(3'd3), w);
      chk("ready_after_push_pop_at7", w, 0);
      @(negedge clk_in);
      chk("full_after_refill", msg_ready, 1'b0);
      @(posedge clk_in);
      #1;
      drain();
      chk("count_issued", issued_count, 32'(exp_issued));

      // Out-of-range stock between two valid ones
      hold = 2;
      n0   = n_starts;
      push(mk(3'd1), w);
      push(mk(3'd4), w);
      push(mk(3'd3), w);
      drain();
      chk("drop_count", dropped_count, 16'd1);
      chk("drop_no_start", n_starts - n0, 2);

      // First request never acknowledged: timeout, next entry still issued
      nack_left = 1;
      push(mk(3'd2), w);
      push(mk(3'd0), w);
      drain();
      sz = start_cyc.size();
      chk("timeout_reissue_gap", start_cyc[sz-1] - start_cyc[sz-2], 6);
      chk("timeout_err", ack_timeout_err, 1'b1);
      chk("timeout_issued", issued_count, 32'(exp_issued));

      // Randomized traffic
      rand_mode = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) push(mk(3'($urandom_range(4, 7))), w);
         else push(mk(3'($urandom_range(0, 3))), w);
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk_in);
            #1;
         end
      end
      drain();
      rand_mode = 1'b0;
      chk("rand_issued", issued_count, 32'(exp_issued));
      chk("rand_dropped", dropped_count, 16'(exp_drop));
      chk("rand_err_sticky", ack_timeout_err, exp_err);

      // Reset during WAIT_DONE with 3 entries queued
      hold = 20;
      for (int i = 0; i < 4; i++) push(mk(3'($urandom_range(0, 3))), w);
      repeat (3) @(posedge clk_in);
      #1;
      chk("pre_reset_in_flight", in_flight, 1'b1);
      rst_in     = 1'b1;
      busy_left  = 0;
      exp_q      = {};
      exp_issued = 0;
      exp_drop   = 0;
      exp_err    = 1'b0;
      @(negedge clk_in);
      chk("ready_in_mid_reset", msg_ready, 1'b0);
      @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      @(negedge clk_in);
      chk("mid_reset_status", {start, in_flight, issued_count, dropped_count, ack_timeout_err}, '0);
      chk("mid_reset_fields", {stock_to_add, order_to_add, request, order_id, req_delete, quantity}, '0);
      chk("mid_reset_ready", msg_ready, 1'b1);
      n0 = n_starts;
      repeat (10) @(negedge clk_in);
      chk("no_start_after_reset", n_starts - n0, 0);
      @(posedge clk_in);
      #1;
      hold = 3;
      push(mk(3'd2), w);
      drain();
      chk("post_reset_issued", issued_count, 32'd1);
      chk("post_reset_err", ack_timeout_err, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish want finish (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

endmodule
